// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared widths and result-source select encodings for writeback.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int C_DATA_WIDTH    = 32;
    localparam int C_ERR_CNT_WIDTH = 8;

    // Result-source encodings shared with the decoder
    localparam logic [3:0] RES_ALU = 4'd0;
    localparam logic [3:0] RES_MEM = 4'd1;
    localparam logic [3:0] RES_PC4 = 4'd2;
    localparam logic [3:0] RES_IMM = 4'd3;

    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_result_sel_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_sel_reg_if
// Brief    : Datapath/control bundle between the MEM stage and writeback register.
// Revision : 1.0
// ============================================================================
interface wb_result_sel_reg_if
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int NUM_INPUTS = 3
);
    localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [SEL_WIDTH-1:0]             sel;
    logic                             in_valid;
    logic                             stall;
    logic                             flush;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic [SEL_WIDTH-1:0]             out_sel;

    modport master (
        output in_data, sel, in_valid, stall, flush,
        input  out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, sel, in_valid, stall, flush,
        output out_data, out_valid, out_sel
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter; increment wins over clear and yields 1.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            if (clr) begin
                r_count <= WIDTH'(1);
            end else if (r_count != '1) begin
                r_count <= r_count + WIDTH'(1);
            end
        end else if (clr) begin
            r_count <= '0;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_result_sel_reg.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_sel_reg
// Brief    : Registered writeback result selector with invalid-select tracking.
// Revision : 1.0
// ============================================================================
module wb_result_sel_reg
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = C_DATA_WIDTH,
    parameter int NUM_INPUTS    = 3,
    parameter int ERR_CNT_WIDTH = C_ERR_CNT_WIDTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     err_clear,
    wb_result_sel_reg_if.slave            bus,
    output logic                          err_pulse,
    output logic                          err_sticky,
    output logic      [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

    logic [DATA_WIDTH-1:0] w_words [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_bad;
    logic                  w_accept;
    logic                  w_err_accept;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [SEL_WIDTH-1:0]  r_out_sel;
    logic                  r_err_pulse;
    logic                  r_err_sticky;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_unpack
        assign w_words[k] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (bus.sel == SEL_WIDTH'(k)) begin
                w_sel_data = w_words[k];
            end
        end
    end

    // Out-of-range codes exist only when NUM_INPUTS is not a power of two
    assign w_sel_bad    = !sel_in_range(32'(bus.sel), NUM_INPUTS);
    assign w_accept     = !bus.flush && !bus.stall;
    assign w_err_accept = w_accept && bus.in_valid && w_sel_bad;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_err_pulse <= 1'b0;
        end else if (bus.stall) begin
            r_err_pulse <= 1'b0;
        end else if (!bus.in_valid) begin
            r_out_valid <= 1'b0;
            r_err_pulse <= 1'b0;
        end else if (w_sel_bad) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= bus.sel;
            r_err_pulse <= 1'b1;
        end else begin
            r_out_data  <= w_sel_data;
            r_out_valid <= 1'b1;
            r_out_sel   <= bus.sel;
            r_err_pulse <= 1'b0;
        end
    end

    // A simultaneous error beats err_clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_err_accept) begin
            r_err_sticky <= 1'b1;
        end else if (err_clear) begin
            r_err_sticky <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (err_clear),
        .inc   (w_err_accept),
        .count (err_count)
    );

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;
    assign err_pulse     = r_err_pulse;
    assign err_sticky    = r_err_sticky;

endmodule
`default_nettype wire
